checker_auto: RTL and testbench
===============================

# checker_auto

Auto-mode checker controller, occupying the `CHECKER_MODE_AUTO` slot in `checker_top` next to `checker_single`. It drives the MPU/hm pair (`mpu_en`, `mpu_rst`) in a repeating measure/report/sleep loop: reset the MPU, run it to completion, report the result, wait a fixed period, repeat. It stops when software drops `mode_start`, `mode_mode` changes, or an error occurs. In `checker_top` it replaces the `mode_*_auto` tie-offs and shares the `mpu_*` control with `checker_single`.

## Interface
Parameters:
- `mode`, default `` `CHECKER_MODE_AUTO ``: `mode_mode` value this block responds to.
- `period`, default 32'd1000000: sleep cycles between iterations; 0 means back-to-back runs.
- `timeout`, default 32'd1000000: max cycles in RUN before a watchdog error; must be ≥1.

Ports:
- `sys_clk` in 1: clock; in `checker_top` this is `sys_clk_2`.
- `sys_rst` in 1: reset; synchronous, active-high.
- `mode_mode` in 2: selected checker mode.
- `mode_start` in 1: level; a high level requests the loop to run.
- `mode_addr` in 64: page address; passed to hm by the top, unused internally.
- `mode_end` out 1: loop stopped; sticky until the next start.
- `mode_data` out 64: `mpu_user_data` latched at the last report.
- `mode_irq` out 1: result available; held until acknowledged.
- `mode_ack` in 1: software acknowledge of `mode_irq`.
- `mode_error` out 1: loop stopped on an MPU error or watchdog timeout.
- `mpu_en` out 1: MPU/hm run enable.
- `mpu_rst` out 1: MPU/hm reset, single-cycle pulse.
- `mpu_error` in 1: OR of MPU error, hm timeout and hm error.
- `mpu_user_data` in 64: MPU result.
- `mpu_user_irq` in 1: MPU signals a result is ready.

## Operation
- All outputs are registered.
- Reset values: all outputs 0, `mode_data` = 0, state = IDLE, both counters = 0.
- `go` = `mode_start` & (`mode_mode` == `mode`).
- **IDLE**
  - If `go`: go to RST; clear `mode_end`, `mode_error` and `mode_irq`.
- **RST**
  - `mpu_rst` = 1, `mpu_en` = 0, for exactly one cycle.
  - Load the watchdog counter with 0, then go to RUN.
- **RUN**
  - `mpu_en` = 1; the watchdog counter increments every cycle.
  - Priority 1, `mpu_error`: go to END and set `mode_error`.
  - Priority 2, `mpu_user_irq`: latch `mpu_user_data` into `mode_data`, set `mode_irq`, go to ACK.
  - Priority 3, watchdog == `timeout`-1: go to END and set `mode_error`.
  - Priority 4, !`go`: go to END (abort); `mode_error` stays 0.
- **ACK**
  - `mpu_en` = 0; `mode_irq` is held.
  - On `mode_ack`: clear `mode_irq`.
    - If !`go`, go to END.
    - Else if `period` == 0, go to RST.
    - Else load the sleep counter with `period` and go to SLEEP.
  - If !`go` while waiting for the ack: stay in ACK (the result must be consumed), then exit to END on ack.
- **SLEEP**
  - `mpu_en` = 0; the sleep counter decrements each cycle.
  - If !`go`: go to END.
  - Else when the counter == 1: go to RST.
- **END**
  - Set `mode_end` (sticky).
  - When !`mode_start`: go to IDLE. `mode_end` and `mode_error` stay set until the next accepted start.
- `mode_ack` is ignored outside ACK.
- Changes to `mpu_user_irq` and `mpu_error` outside RUN are ignored.
- Counters are 32-bit unsigned; no wrap is possible, since the watchdog exits at `timeout`-1.
- A `sys_rst` assertion in any state returns the block to reset values on the next edge; `mpu_rst` is not pulsed by this block on `sys_rst` (the top ORs `sys_rst` in).

## Timing
- A `go` sampled high at edge N gives `mpu_rst` = 1 for cycle N+1, and `mpu_en` = 1 from N+2.
- `mpu_user_irq` sampled at edge M:
  - `mode_irq` and `mode_data` are valid from M+1.
  - `mpu_en` is 0 from M+1.
- `mode_ack` sampled at edge A: `mode_irq` is 0 from A+1.
- Next `mpu_rst` pulse:
  - at A+1 when `period` == 0;
  - otherwise at A+1+`period`.
- Watchdog: RUN lasts at most `timeout` cycles; `mode_error` and `mode_end` are set on the following edge.
- Stop latency (`go` falls in RUN or SLEEP): `mpu_en` is 0 and `mode_end` is 1 one cycle later.

## Test plan
- **Basic loop:** `period`=4. Assert `go`; MPU raises irq with data 64'hDEAD_BEEF_0000_0001 after 10 RUN cycles; ack 2 cycles later.
  - Expect `mpu_rst` pulse, then `mpu_en` high for 10 cycles.
  - Expect `mode_irq` with that data, then the next `mpu_rst` exactly 4 cycles after ack is registered.
- **Back-to-back:** `period`=0, three iterations with data values 1, 2, 3.
  - Expect three `mpu_rst` pulses, each one cycle after its ack.
  - Expect `mode_data` to follow 1, 2, 3.
- **MPU error:** `mpu_error` and `mpu_user_irq` asserted together in RUN.
  - Expect `mode_error` = 1 and `mode_end` = 1; `mode_irq` stays 0; `mpu_en` = 0.
- **Watchdog:** `timeout`=8, no irq.
  - Expect `mpu_en` high for exactly 8 cycles, then `mode_error` = 1 and `mode_end` = 1.
- **Stop:**
  - Drop `mode_start` in SLEEP: `mode_end` = 1 the next cycle, with no further `mpu_rst`.
  - Drop it in ACK: `mode_irq` is held until ack, then END.
- **Reset and mode change:**
  - `sys_rst` during RUN: all outputs 0 the next cycle.
  - `mode_mode` switched to SINGLE during RUN: abort to END with `mode_error` = 0.

Source files
------------

// File: rtl/checker_auto.sv
`default_nettype none

`ifndef CHECKER_MODE_AUTO
`define CHECKER_MODE_AUTO 2'd2
`endif

// ============================================================================
// Module   : checker_auto
// Purpose  : Auto-mode checker controller. Runs the MPU/hm pair in a repeating
//            loop: reset the MPU, run it until it reports, hold the result
//            for software, sleep a fixed period, then repeat. The loop stops
//            when software drops mode_start, mode_mode leaves this mode, an
//            MPU error is reported, or the RUN watchdog expires.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   mode          mode_mode value this block responds to
//   period        sleep cycles between iterations (0 = back-to-back)
//   timeout       max cycles spent in RUN before a watchdog error (>= 1)
// Ports
//   sys_clk       clock
//   sys_rst       synchronous active-high reset
//   mode_mode     selected checker mode
//   mode_start    level request to run the loop
//   mode_addr     page address (consumed by hm at the top level only)
//   mode_end      loop stopped, sticky until the next accepted start
//   mode_data     MPU result latched at the last report
//   mode_irq      result available, held until mode_ack
//   mode_ack      software acknowledge of mode_irq
//   mode_error    loop stopped on MPU error or watchdog timeout
//   mpu_en        MPU/hm run enable
//   mpu_rst       MPU/hm reset, single-cycle pulse
//   mpu_error     OR of MPU error, hm timeout and hm error
//   mpu_user_data MPU result
//   mpu_user_irq  MPU result ready
// ============================================================================
module checker_auto #(
    parameter logic [1:0]  mode    = `CHECKER_MODE_AUTO,
    parameter logic [31:0] period  = 32'd1000000,
    parameter logic [31:0] timeout = 32'd1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [1:0]  mode_mode,
    input  logic        mode_start,
    input  logic [63:0] mode_addr,
    output logic        mode_end,
    output logic [63:0] mode_data,
    output logic        mode_irq,
    input  logic        mode_ack,
    output logic        mode_error,
    output logic        mpu_en,
    output logic        mpu_rst,
    input  logic        mpu_error,
    input  logic [63:0] mpu_user_data,
    input  logic        mpu_user_irq
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_ACK   = 3'd3,
        S_SLEEP = 3'd4,
        S_END   = 3'd5
    } state_t;

    localparam logic [31:0] c_wdog_last = timeout - 32'd1;

    state_t      r_state;
    logic [31:0] r_wdog;
    logic [31:0] r_sleep;

    logic        w_go;
    // The page address is routed to hm by the top level; it is folded into
    // an explicitly-unused net so the port is documented but carries no logic.
    logic        w_unused_addr;

    assign w_go          = mode_start && (mode_mode == mode);
    assign w_unused_addr = ^mode_addr;

    // Outputs are written on the edge that enters the state they belong to,
    // so every output is a flop and follows the state with no extra latency.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_wdog     <= 32'd0;
            r_sleep    <= 32'd0;
            mode_end   <= 1'b0;
            mode_data  <= 64'd0;
            mode_irq   <= 1'b0;
            mode_error <= 1'b0;
            mpu_en     <= 1'b0;
            mpu_rst    <= 1'b0;
        end else begin
            // mpu_rst is a one-cycle pulse; only entering RST raises it
            mpu_rst <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    mpu_en <= 1'b0;
                    if (w_go) begin
                        r_state    <= S_RST;
                        mpu_rst    <= 1'b1;
                        mode_end   <= 1'b0;
                        mode_error <= 1'b0;
                        mode_irq   <= 1'b0;
                    end
                end

                S_RST: begin
                    // RST always lasts exactly one cycle, go is not sampled
                    r_wdog  <= 32'd0;
                    mpu_en  <= 1'b1;
                    r_state <= S_RUN;
                end

                S_RUN: begin
                    r_wdog <= r_wdog + 32'd1;
                    if (mpu_error) begin
                        // An error wins over a simultaneous result
                        r_state    <= S_END;
                        mpu_en     <= 1'b0;
                        mode_error <= 1'b1;
                        mode_end   <= 1'b1;
                    end else if (mpu_user_irq) begin
                        r_state   <= S_ACK;
                        mpu_en    <= 1'b0;
                        mode_data <= mpu_user_data;
                        mode_irq  <= 1'b1;
                    end else if (r_wdog == c_wdog_last) begin
                        // RUN has lasted 'timeout' cycles including this one
                        r_state    <= S_END;
                        mpu_en     <= 1'b0;
                        mode_error <= 1'b1;
                        mode_end   <= 1'b1;
                    end else if (!w_go) begin
                        r_state  <= S_END;
                        mpu_en   <= 1'b0;
                        mode_end <= 1'b1;
                    end
                end

                S_ACK: begin
                    // A pending result must be consumed even if go drops,
                    // so only the ack moves us out of this state.
                    mpu_en <= 1'b0;
                    if (mode_ack) begin
                        mode_irq <= 1'b0;
                        if (!w_go) begin
                            r_state  <= S_END;
                            mode_end <= 1'b1;
                        end else if (period == 32'd0) begin
                            r_state <= S_RST;
                            mpu_rst <= 1'b1;
                        end else begin
                            r_sleep <= period;
                            r_state <= S_SLEEP;
                        end
                    end
                end

                S_SLEEP: begin
                    mpu_en  <= 1'b0;
                    r_sleep <= r_sleep - 32'd1;
                    if (!w_go) begin
                        r_state  <= S_END;
                        mode_end <= 1'b1;
                    end else if (r_sleep == 32'd1) begin
                        // Counter was loaded with 'period', so SLEEP spans
                        // exactly 'period' cycles before the next RST.
                        r_state <= S_RST;
                        mpu_rst <= 1'b1;
                    end
                end

                S_END: begin
                    mpu_en   <= 1'b0;
                    mode_end <= 1'b1;
                    // Wait for the start level itself to drop so a mode
                    // change alone does not re-arm the loop.
                    if (!mode_start) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    mpu_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_checker_auto.sv
`default_nettype none

// ============================================================================
// Module   : tb_checker_auto
// Purpose  : Self-checking bench for checker_auto. Two instances share the
//            MPU-side stimulus: u_dut_a (period 4) for the sleeping loop and
//            u_dut_b (period 0, timeout 8) for back-to-back runs and the
//            watchdog. Each instance has its own mode_start so only one is
//            active at a time. Reported MPU data is tracked in a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_checker_auto;

    localparam logic [1:0] c_auto   = 2'd2;
    localparam logic [1:0] c_single = 2'd1;

    logic        sys_clk;
    logic        sys_rst;
    logic [1:0]  mode_mode;
    logic        start_a;
    logic        start_b;
    logic [63:0] mode_addr;
    logic        mode_ack;
    logic        mpu_error;
    logic [63:0] mpu_user_data;
    logic        mpu_user_irq;

    logic        a_end, a_irq, a_error, a_en, a_rst;
    logic [63:0] a_data;
    logic        b_end, b_irq, b_error, b_en, b_rst;
    logic [63:0] b_data;

    logic [63:0] exp_q[$];
    logic [63:0] r_exp;
    int          n_cmp;
    int          n_bad;

    checker_auto #(.mode(c_auto), .period(32'd4), .timeout(32'd1000)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_mode(mode_mode),
        .mode_start(start_a), .mode_addr(mode_addr), .mode_end(a_end),
        .mode_data(a_data), .mode_irq(a_irq), .mode_ack(mode_ack),
        .mode_error(a_error), .mpu_en(a_en), .mpu_rst(a_rst),
        .mpu_error(mpu_error), .mpu_user_data(mpu_user_data),
        .mpu_user_irq(mpu_user_irq)
    );

    checker_auto #(.mode(c_auto), .period(32'd0), .timeout(32'd8)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_mode(mode_mode),
        .mode_start(start_b), .mode_addr(mode_addr), .mode_end(b_end),
        .mode_data(b_data), .mode_irq(b_irq), .mode_ack(mode_ack),
        .mode_error(b_error), .mpu_en(b_en), .mpu_rst(b_rst),
        .mpu_error(mpu_error), .mpu_user_data(mpu_user_data),
        .mpu_user_irq(mpu_user_irq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // Advance one edge; inputs and observations happen 1 time unit after it
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Present a result to the MPU side and record what must be reported
    task automatic drive_result(input logic [63:0] d);
        mpu_user_irq  = 1'b1;
        mpu_user_data = d;
        exp_q.push_back(d);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        n_cmp++;
        if ({a_end, a_irq, a_error, a_en, a_rst, a_data} !== 69'd0) begin
            n_bad++;
            $display("FAIL reset_a: got end=%b irq=%b err=%b en=%b rst=%b data=%h want all 0",
                     a_end, a_irq, a_error, a_en, a_rst, a_data);
        end
        n_cmp++;
        if ({b_end, b_irq, b_error, b_en, b_rst, b_data} !== 69'd0) begin
            n_bad++;
            $display("FAIL reset_b: got end=%b irq=%b err=%b en=%b rst=%b data=%h want all 0",
                     b_end, b_irq, b_error, b_en, b_rst, b_data);
        end
    endtask

    task automatic test_basic_loop();
        int en_bad;
        int rst_seen;
        start_a = 1'b1;
        tick();
        n_cmp++;
        if ({a_rst, a_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL basic_rst_pulse: got rst=%b en=%b want rst=1 en=0", a_rst, a_en);
        end
        tick();
        en_bad = 0;
        for (int i = 1; i <= 10; i++) begin
            if (a_en !== 1'b1 || a_rst !== 1'b0) en_bad++;
            if (i == 10) drive_result(64'hDEAD_BEEF_0000_0001);
            else tick();
        end
        n_cmp++;
        if (en_bad != 0) begin
            n_bad++;
            $display("FAIL basic_en_window: got %0d bad RUN cycles want 0", en_bad);
        end
        tick();
        mpu_user_irq = 1'b0;
        n_cmp++;
        if ({a_irq, a_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL basic_irq: got irq=%b en=%b want irq=1 en=0", a_irq, a_en);
        end
        r_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        n_cmp++;
        if (a_data !== r_exp) begin
            n_bad++;
            $display("FAIL basic_data: got %h want %h", a_data, r_exp);
        end
        tick();
        tick();
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        n_cmp++;
        if (a_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_irq_clear: got %b want 0", a_irq);
        end
        // next mpu_rst must appear in cycle A+1+4, i.e. the 5th observation
        rst_seen = 0;
        for (int i = 1; i <= 5; i++) begin
            if (a_rst === 1'b1) rst_seen = i;
            if (i < 5) tick();
        end
        n_cmp++;
        if (rst_seen != 5) begin
            n_bad++;
            $display("FAIL basic_period: got mpu_rst at slot %0d want 5", rst_seen);
        end
        start_a = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        start_b = 1'b1;
        tick();
        tick();
        for (int it = 1; it <= 3; it++) begin
            tick();
            tick();
            drive_result(64'(it));
            tick();
            mpu_user_irq = 1'b0;
            n_cmp++;
            if (b_irq !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_irq_%0d: got %b want 1", it, b_irq);
            end
            r_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
            n_cmp++;
            if (b_data !== r_exp) begin
                n_bad++;
                $display("FAIL b2b_data_%0d: got %h want %h", it, b_data, r_exp);
            end
            tick();
            mode_ack = 1'b1;
            tick();
            mode_ack = 1'b0;
            n_cmp++;
            if ({b_rst, b_irq} !== 2'b10) begin
                n_bad++;
                $display("FAIL b2b_rst_%0d: got rst=%b irq=%b want rst=1 irq=0", it, b_rst, b_irq);
            end
            tick();
        end
        start_b = 1'b0;
        tick();
        n_cmp++;
        if ({b_end, b_error, b_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_stop: got end=%b err=%b en=%b want 1 0 0", b_end, b_error, b_en);
        end
        tick();
    endtask

    task automatic test_mpu_error();
        start_a = 1'b1;
        tick();
        tick();
        tick();
        mpu_error     = 1'b1;
        mpu_user_irq  = 1'b1;
        mpu_user_data = 64'h5555_5555_5555_5555;
        tick();
        mpu_error    = 1'b0;
        mpu_user_irq = 1'b0;
        n_cmp++;
        if ({a_error, a_end, a_irq, a_en} !== 4'b1100) begin
            n_bad++;
            $display("FAIL mpu_error: got err=%b end=%b irq=%b en=%b want 1 1 0 0",
                     a_error, a_end, a_irq, a_en);
        end
        start_a = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({a_error, a_end} !== 2'b11) begin
            n_bad++;
            $display("FAIL error_sticky: got err=%b end=%b want 1 1", a_error, a_end);
        end
    endtask

    task automatic test_watchdog();
        int cnt;
        start_b = 1'b1;
        tick();
        tick();
        cnt = 0;
        while (b_en === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt != 8) begin
            n_bad++;
            $display("FAIL watchdog_len: got %0d RUN cycles want 8", cnt);
        end
        n_cmp++;
        if ({b_error, b_end} !== 2'b11) begin
            n_bad++;
            $display("FAIL watchdog_flags: got err=%b end=%b want 1 1", b_error, b_end);
        end
        start_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stop();
        int rst_cnt;
        // drop the request while sleeping
        start_a = 1'b1;
        tick();
        n_cmp++;
        if ({a_end, a_error} !== 2'b00) begin
            n_bad++;
            $display("FAIL restart_clear: got end=%b err=%b want 0 0", a_end, a_error);
        end
        tick();
        tick();
        drive_result(64'h1111_2222_3333_4444);
        tick();
        mpu_user_irq = 1'b0;
        r_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        n_cmp++;
        if (a_data !== r_exp) begin
            n_bad++;
            $display("FAIL stop_sleep_data: got %h want %h", a_data, r_exp);
        end
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        tick();
        start_a = 1'b0;
        tick();
        n_cmp++;
        if ({a_end, a_en, a_rst} !== 3'b100) begin
            n_bad++;
            $display("FAIL stop_sleep: got end=%b en=%b rst=%b want 1 0 0", a_end, a_en, a_rst);
        end
        rst_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_rst === 1'b1) rst_cnt++;
        end
        n_cmp++;
        if (rst_cnt != 0) begin
            n_bad++;
            $display("FAIL stop_sleep_norst: got %0d mpu_rst pulses want 0", rst_cnt);
        end

        // drop the request while a result waits for the ack
        start_a = 1'b1;
        tick();
        tick();
        drive_result(64'hCAFE_F00D_0000_0042);
        tick();
        mpu_user_irq = 1'b0;
        r_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        n_cmp++;
        if (a_data !== r_exp) begin
            n_bad++;
            $display("FAIL stop_ack_data: got %h want %h", a_data, r_exp);
        end
        start_a = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({a_irq, a_end} !== 2'b10) begin
            n_bad++;
            $display("FAIL stop_ack_hold: got irq=%b end=%b want 1 0", a_irq, a_end);
        end
        mode_ack = 1'b1;
        tick();
        mode_ack = 1'b0;
        n_cmp++;
        if ({a_irq, a_end, a_error} !== 3'b010) begin
            n_bad++;
            $display("FAIL stop_ack_end: got irq=%b end=%b err=%b want 0 1 0", a_irq, a_end, a_error);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_and_mode();
        start_a = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (a_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_run_en: got %b want 1", a_en);
        end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        n_cmp++;
        if ({a_end, a_irq, a_error, a_en, a_rst, a_data} !== 69'd0) begin
            n_bad++;
            $display("FAIL rst_in_run: got end=%b irq=%b err=%b en=%b rst=%b data=%h want all 0",
                     a_end, a_irq, a_error, a_en, a_rst, a_data);
        end
        tick();
        n_cmp++;
        if (a_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_restart: got mpu_rst=%b want 1", a_rst);
        end
        tick();
        mode_mode = c_single;
        tick();
        n_cmp++;
        if ({a_end, a_error, a_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL mode_change: got end=%b err=%b en=%b want 1 0 0", a_end, a_error, a_en);
        end
        mode_mode = c_auto;
        start_a   = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        sys_rst       = 1'b1;
        mode_mode     = c_auto;
        start_a       = 1'b0;
        start_b       = 1'b0;
        mode_addr     = 64'h0000_1000_0000_0000;
        mode_ack      = 1'b0;
        mpu_error     = 1'b0;
        mpu_user_data = 64'd0;
        mpu_user_irq  = 1'b0;

        test_reset();
        test_basic_loop();
        test_back_to_back();
        test_mpu_error();
        test_watchdog();
        test_stop();
        test_reset_and_mode();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
